// File: rtl/aliens_pkg.sv
// Shared alien formation geometry and state encoding (also used by the draw stage).
package aliens_pkg;

    localparam int GRID_ROWS = 5;
    localparam int GRID_COLS = 10;
    localparam int GRID_BITS = GRID_ROWS * GRID_COLS;
    localparam int CELL_W    = 30;
    localparam int CELL_H    = 20;
    localparam int COL_PITCH = 40;
    localparam int ROW_PITCH = 30;
    localparam int SCREEN_W  = 640;

    typedef enum logic [1:0] {
        MARCH_R = 2'd0,
        MARCH_L = 2'd1,
        CLEARED = 2'd2,
        LANDED  = 2'd3
    } alien_state_t;

endpackage

// File: rtl/alien_hit_index.sv
// Combinational bullet-to-alien lookup: maps a bullet pixel onto the formation
// grid and reports whether it lands inside a live alien cell.
module alien_hit_index
    import aliens_pkg::*;
(
    input  logic [8:0]  i_aliens_row,
    input  logic [9:0]  i_aliens_col,
    input  logic [8:0]  i_bullet_row,
    input  logic [9:0]  i_bullet_col,
    input  logic        i_bullet_exists,
    input  logic [49:0] i_grid,
    output logic        o_hit_valid,
    output logic [5:0]  o_hit_index
);

    logic [9:0] w_dx;
    logic [8:0] w_dy;
    logic [9:0] w_col;
    logic [9:0] w_dx_rem;
    logic [8:0] w_row;
    logic [8:0] w_dy_rem;

    // Offset into the formation, split into cell coordinate and in-pitch remainder
    always_comb begin
        o_hit_valid = 1'b0;
        o_hit_index = '0;
        w_dx        = i_bullet_col - i_aliens_col;
        w_dy        = i_bullet_row - i_aliens_row;
        w_col       = w_dx / 10'(COL_PITCH);
        w_dx_rem    = w_dx % 10'(COL_PITCH);
        w_row       = w_dy / 9'(ROW_PITCH);
        w_dy_rem    = w_dy % 9'(ROW_PITCH);
        if (i_bullet_exists &&
            (i_bullet_col >= i_aliens_col) && (i_bullet_row >= i_aliens_row) &&
            (w_col < 10'(GRID_COLS)) && (w_dx_rem < 10'(CELL_W)) &&
            (w_row < 9'(GRID_ROWS))  && (w_dy_rem < 9'(CELL_H))) begin
            o_hit_index = 6'(w_row) * 6'(GRID_COLS) + 6'(w_col);
            o_hit_valid = i_grid[o_hit_index];
        end
    end

endmodule

// File: rtl/alien_formation_ctrl.sv
// Alien formation controller: marches a 5x10 formation across the screen,
// drops on edge reversal, removes aliens hit by the bullet, and reports
// cleared/landed terminal conditions.
// Optional build macro: ALIEN_SPEEDUP_EN (step period shrinks as aliens die).
module alien_formation_ctrl
    import aliens_pkg::*;
#(
    parameter int STEP_FRAMES = 30,
    parameter int STEP_X      = 10,
    parameter int STEP_Y      = 10,
    parameter int COL_INIT    = 40,
    parameter int ROW_INIT    = 40,
    parameter int LAND_ROW    = 400
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        FrameTick,
    input  logic [8:0]  BulletRow,
    input  logic [9:0]  BulletCol,
    input  logic        BulletExists,
    output logic [49:0] Aliens_Grid,
    output logic [8:0]  AliensRow,
    output logic [9:0]  AliensCol,
    output logic        BulletHit,
    output logic        AliensCleared,
    output logic        AliensLanded
);

    localparam logic [15:0] P_FULL = 16'((STEP_FRAMES < 1) ? 1 : STEP_FRAMES);

    alien_state_t r_state;
    logic [49:0]  r_grid;
    logic [8:0]   r_row;
    logic [9:0]   r_col;
    logic [15:0]  r_count;
    logic         r_hit;
    logic         r_cleared;
    logic         r_landed;

    logic         w_hit_valid;
    logic [5:0]   w_hit_idx;
    logic [49:0]  w_grid_post;
    logic [3:0]   w_rc;
    logic [2:0]   w_lr;
    logic [11:0]  w_right_edge;
    logic [8:0]   w_next_row;
    logic [9:0]   w_next_col;
    alien_state_t w_next_state;
    logic [10:0]  w_bottom;
    logic         w_land;
    logic [15:0]  w_period;
    logic         w_period_chg;
    logic [15:0]  w_count_next;
    logic         w_step;

    alien_hit_index u_hit (
        .i_aliens_row    (r_row),
        .i_aliens_col    (r_col),
        .i_bullet_row    (BulletRow),
        .i_bullet_col    (BulletCol),
        .i_bullet_exists (BulletExists),
        .i_grid          (r_grid),
        .o_hit_valid     (w_hit_valid),
        .o_hit_index     (w_hit_idx)
    );

`ifdef ALIEN_SPEEDUP_EN
    localparam logic [15:0] P_HALF    = 16'(((STEP_FRAMES / 2) < 1) ? 1 : (STEP_FRAMES / 2));
    localparam logic [15:0] P_QUARTER = 16'(((STEP_FRAMES / 4) < 1) ? 1 : (STEP_FRAMES / 4));

    logic [5:0]  w_live;
    logic [15:0] r_period;

    // Live-alien count selects the march period
    always_comb begin
        w_live = '0;
        for (int unsigned i = 0; i < GRID_BITS; i++) begin
            w_live = w_live + 6'(r_grid[i]);
        end
        if (w_live > 6'd25)
            w_period = P_FULL;
        else if (w_live > 6'd10)
            w_period = P_HALF;
        else
            w_period = P_QUARTER;
        w_period_chg = (w_period != r_period);
    end

    // Remember the period in force so a change can restart the frame counter
    always_ff @(posedge Clk) begin
        if (Reset)
            r_period <= P_FULL;
        else
            r_period <= w_period;
    end
`else
    assign w_period     = P_FULL;
    assign w_period_chg = 1'b0;
`endif

    // Frame counter: one step each time the counter wraps on a FrameTick
    always_comb begin
        w_step       = 1'b0;
        w_count_next = r_count;
        if (w_period_chg) begin
            w_count_next = '0;
        end else if (FrameTick) begin
            if (r_count >= w_period - 16'd1) begin
                w_count_next = '0;
                w_step       = 1'b1;
            end else begin
                w_count_next = r_count + 16'd1;
            end
        end
    end

    // Post-hit grid drives edge and landing checks so a same-cycle hit counts
    always_comb begin
        w_grid_post = r_grid;
        if (w_hit_valid)
            w_grid_post[w_hit_idx] = 1'b0;
        w_rc = '0;
        w_lr = '0;
        for (int unsigned c = 0; c < GRID_COLS; c++) begin
            for (int unsigned r = 0; r < GRID_ROWS; r++) begin
                if (w_grid_post[r * GRID_COLS + c]) begin
                    w_rc = 4'(c);
                end
            end
        end
        for (int unsigned r = 0; r < GRID_ROWS; r++) begin
            for (int unsigned c = 0; c < GRID_COLS; c++) begin
                if (w_grid_post[r * GRID_COLS + c]) begin
                    w_lr = 3'(r);
                end
            end
        end
        w_right_edge = 12'(r_col) + 12'(COL_PITCH) * 12'(w_rc) + 12'(CELL_W + STEP_X);
        w_next_row   = r_row;
        w_next_col   = r_col;
        w_next_state = r_state;
        if (r_state == MARCH_R) begin
            if (w_right_edge > 12'(SCREEN_W - 1)) begin
                w_next_row   = r_row + 9'(STEP_Y);
                w_next_state = MARCH_L;
            end else begin
                w_next_col   = r_col + 10'(STEP_X);
            end
        end else if (r_state == MARCH_L) begin
            if (r_col < 10'(STEP_X)) begin
                w_next_row   = r_row + 9'(STEP_Y);
                w_next_state = MARCH_R;
            end else begin
                w_next_col   = r_col - 10'(STEP_X);
            end
        end
        w_bottom = 11'(w_next_row) + 11'(ROW_PITCH) * 11'(w_lr) + 11'(CELL_H);
        w_land   = (w_bottom >= 11'(LAND_ROW));
    end

    // Formation FSM with registered position, grid and status outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= MARCH_R;
            r_grid    <= '1;
            r_row     <= 9'(ROW_INIT);
            r_col     <= 10'(COL_INIT);
            r_count   <= '0;
            r_hit     <= 1'b0;
            r_cleared <= 1'b0;
            r_landed  <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                MARCH_R, MARCH_L: begin
                    r_hit   <= w_hit_valid;
                    r_grid  <= w_grid_post;
                    r_count <= w_count_next;
                    if (w_grid_post == '0) begin
                        r_state   <= CLEARED;
                        r_cleared <= 1'b1;
                    end else if (w_step) begin
                        r_row <= w_next_row;
                        r_col <= w_next_col;
                        if (w_land) begin
                            r_state  <= LANDED;
                            r_landed <= 1'b1;
                        end else begin
                            r_state  <= w_next_state;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign Aliens_Grid   = r_grid;
    assign AliensRow     = r_row;
    assign AliensCol     = r_col;
    assign BulletHit     = r_hit;
    assign AliensCleared = r_cleared;
    assign AliensLanded  = r_landed;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Directed bench for alien_formation_ctrl (default build, speedup disabled).
module tb_alien_formation_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_a, tick_b, tick_c;
    logic [8:0]  b_row;
    logic [9:0]  b_col;
    logic        b_exists;
    logic        no_bullet;

    logic [49:0] grid_a, grid_b, grid_c;
    logic [8:0]  row_a, row_b, row_c;
    logic [9:0]  col_a, col_b, col_c;
    logic        hit_a, hit_b, hit_c;
    logic        clr_a, clr_b, clr_c;
    logic        land_a, land_b, land_c;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [49:0] exp_grid;

    always #5 clk = ~clk;

    alien_formation_ctrl u_dut (
        .Clk(clk), .Reset(rst), .FrameTick(tick_a),
        .BulletRow(b_row), .BulletCol(b_col), .BulletExists(b_exists),
        .Aliens_Grid(grid_a), .AliensRow(row_a), .AliensCol(col_a),
        .BulletHit(hit_a), .AliensCleared(clr_a), .AliensLanded(land_a)
    );

    alien_formation_ctrl #(.STEP_FRAMES(1), .COL_INIT(250)) u_edge (
        .Clk(clk), .Reset(rst), .FrameTick(tick_b),
        .BulletRow(b_row), .BulletCol(b_col), .BulletExists(no_bullet),
        .Aliens_Grid(grid_b), .AliensRow(row_b), .AliensCol(col_b),
        .BulletHit(hit_b), .AliensCleared(clr_b), .AliensLanded(land_b)
    );

    alien_formation_ctrl #(.STEP_FRAMES(1), .ROW_INIT(270)) u_land (
        .Clk(clk), .Reset(rst), .FrameTick(tick_c),
        .BulletRow(b_row), .BulletCol(b_col), .BulletExists(no_bullet),
        .Aliens_Grid(grid_c), .AliensRow(row_c), .AliensCol(col_c),
        .BulletHit(hit_c), .AliensCleared(clr_c), .AliensLanded(land_c)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_a(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            tick_a = 1'b1; cyc();
            tick_a = 1'b0; cyc();
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic shoot(input logic [8:0] r, input logic [9:0] c);
        b_row = r; b_col = c; b_exists = 1'b1;
        cyc();
        b_exists = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick_a = 0; tick_b = 0; tick_c = 0;
        b_row = '0; b_col = '0; b_exists = 0; no_bullet = 0;
        cyc(); cyc();
        rst = 1'b0;
        exp_grid = '1;

        // reset state
        check("rst_grid", 64'(grid_a), 64'(exp_grid));
        check("rst_row", 64'(row_a), 64'd40);
        check("rst_col", 64'(col_a), 64'd40);
        check("rst_hit", 64'(hit_a), 64'd0);
        check("rst_clr", 64'(clr_a), 64'd0);
        check("rst_land", 64'(land_a), 64'd0);

        // hit on column 1, row 0
        shoot(9'd45, 10'd85);
        exp_grid[1] = 1'b0;
        check("hit1_grid", 64'(grid_a), 64'(exp_grid));
        check("hit1_pulse", 64'(hit_a), 64'd1);
        cyc();
        check("hit1_pulse_end", 64'(hit_a), 64'd0);
        shoot(9'd45, 10'd85);
        check("dead_cell_pulse", 64'(hit_a), 64'd0);
        check("dead_cell_grid", 64'(grid_a), 64'(exp_grid));

        // gaps and out-of-formation bullets
        shoot(9'd45, 10'd75);
        check("gap_x_pulse", 64'(hit_a), 64'd0);
        check("gap_x_grid", 64'(grid_a), 64'(exp_grid));
        shoot(9'd60, 10'd45);
        check("gap_y_grid", 64'(grid_a), 64'(exp_grid));
        shoot(9'd45, 10'd39);
        check("left_of_grid", 64'(grid_a), 64'(exp_grid));

        // top-left corner pixel is inside cell 0
        shoot(9'd40, 10'd40);
        exp_grid[0] = 1'b0;
        check("corner_grid", 64'(grid_a), 64'(exp_grid));
        check("corner_pulse", 64'(hit_a), 64'd1);

        // march timing from fresh reset
        rst = 1'b1; cyc(); rst = 1'b0;
        exp_grid = '1;
        check("rst2_grid", 64'(grid_a), 64'(exp_grid));
        frame_a(29);
        check("f29_col", 64'(col_a), 64'd40);
        frame_a(1);
        check("f30_col", 64'(col_a), 64'd50);
        check("f30_row", 64'(row_a), 64'd40);
        frame_a(30);
        check("f60_col_still_right", 64'(col_a), 64'd60);

        // reset wins over a simultaneous step
        frame_a(29);
        tick_a = 1'b1; rst = 1'b1; cyc();
        tick_a = 1'b0; rst = 1'b0;
        check("rst_vs_step_col", 64'(col_a), 64'd40);
        frame_a(29);
        check("rst_vs_step_cnt", 64'(col_a), 64'd40);
        frame_a(1);
        check("rst_vs_step_cnt2", 64'(col_a), 64'd50);

        // clear all aliens
        rst = 1'b1; cyc(); rst = 1'b0;
        exp_grid = '1;
        for (int i = 0; i < 50; i++) begin
            shoot(9'(40 + 30 * (i / 10) + 5), 10'(40 + 40 * (i % 10) + 5));
            exp_grid[i] = 1'b0;
            check($sformatf("clear_bit%0d", i), 64'(grid_a), 64'(exp_grid));
        end
        check("cleared_flag", 64'(clr_a), 64'd1);
        frame_a(30);
        check("cleared_col", 64'(col_a), 64'd40);
        check("cleared_row", 64'(row_a), 64'd40);
        check("cleared_hold", 64'(clr_a), 64'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("cleared_rst_flag", 64'(clr_a), 64'd0);
        check("cleared_rst_grid", 64'(grid_a), 64'(50'h3_FFFF_FFFF_FFFF));

        // right edge reversal (COL_INIT 250)
        check("edge_rst_col", 64'(col_b), 64'd250);
        tick_b = 1'b1; cyc(); tick_b = 1'b0;
        check("edge_row", 64'(row_b), 64'd50);
        check("edge_col", 64'(col_b), 64'd250);
        cyc();
        tick_b = 1'b1; cyc(); tick_b = 1'b0;
        check("edge_then_left_col", 64'(col_b), 64'd240);
        check("edge_then_left_row", 64'(row_b), 64'd50);

        // landing (ROW_INIT 270): bottom 270+120+20 = 410
        tick_c = 1'b1; cyc(); tick_c = 1'b0;
        check("land_flag", 64'(land_c), 64'd1);
        check("land_col", 64'(col_c), 64'd50);
        check("land_row", 64'(row_c), 64'd270);
        tick_c = 1'b1; cyc(); tick_c = 1'b0;
        check("land_frozen_col", 64'(col_c), 64'd50);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("land_rst_flag", 64'(land_c), 64'd0);
        check("land_rst_col", 64'(col_c), 64'd40);
        check("land_rst_row", 64'(row_c), 64'd270);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alien_formation_ctrl.md
ALIEN_FORMATION_CTRL -- requirements
Module: alien_formation_ctrl

Interface
REQ-001 Parameter STEP_FRAMES, default 30: frame ticks between formation steps.
REQ-002 Parameter STEP_X, default 10: horizontal step in pixels.
REQ-003 Parameter STEP_Y, default 10: vertical drop in pixels on edge reversal.
REQ-004 Parameter COL_INIT, default 40: reset formation column.
REQ-005 Parameter ROW_INIT, default 40: reset formation row.
REQ-006 Parameter LAND_ROW, default 400: row at which the formation has landed.
REQ-007 Clk  input  1  system clock.
REQ-008 Reset  input  1  reset, synchronous, active-high.
REQ-009 FrameTick  input  1  one-cycle pulse per video frame.
REQ-010 BulletRow  input  9  bullet pixel row.
REQ-011 BulletCol  input  10  bullet pixel column.
REQ-012 BulletExists  input  1  bullet live.
REQ-013 Aliens_Grid  output  50  live mask; bit row*10+col.
REQ-014 AliensRow  output  9  formation top row.
REQ-015 AliensCol  output  10  formation left column.
REQ-016 BulletHit  output  1  one-cycle pulse when an alien is destroyed.
REQ-017 AliensCleared  output  1  level; all aliens destroyed.
REQ-018 AliensLanded  output  1  level; formation reached LAND_ROW.

Function
REQ-019 Geometry SHALL be: 5 rows x 10 cols; cell 30 wide x 20 high; column pitch 40, row pitch 30.
REQ-020 States SHALL be MARCH_R, MARCH_L, CLEARED, LANDED; all outputs registered.
REQ-021 Hit: in MARCH_*, with BulletExists=1, dx=BulletCol-AliensCol, dy=BulletRow-AliensRow, both non-negative, dx/40<10, dx%40<30, dy/30<5, dy%30<20, and the addressed bit set -> clear that bit and pulse BulletHit the next cycle.
REQ-022 At most one bit SHALL clear per cycle; a bullet in a gap or on a dead cell has no effect.
REQ-023 Frame counter SHALL increment on FrameTick; on FrameTick with count == period-1, it wraps to 0 and one step occurs.
REQ-024 MARCH_R step: if AliensCol+40*rc+30+STEP_X > 639 (rc = rightmost live column), AliensRow += STEP_Y and go MARCH_L; else AliensCol += STEP_X.
REQ-025 MARCH_L step: if AliensCol < STEP_X, AliensRow += STEP_Y and go MARCH_R; else AliensCol -= STEP_X (AliensCol never below 0).
REQ-026 After any step, if AliensRow+30*lr+20 >= LAND_ROW (lr = lowest live row), go LANDED, AliensLanded=1.
REQ-027 Grid == 0 SHALL go CLEARED, AliensCleared=1, next cycle.
REQ-028 CLEARED and LANDED SHALL be terminal until Reset; position and grid frozen; no hits.
REQ-029 Hit and step in the same cycle: hit evaluated against pre-step position; the step's edge and landing checks use the post-hit grid.

Reset
REQ-030 Reset SHALL set Aliens_Grid to all ones, AliensRow=ROW_INIT, AliensCol=COL_INIT, state MARCH_R, counter 0, BulletHit/AliensCleared/AliensLanded 0.
REQ-031 Reset SHALL take priority over hit and step in the same cycle, including mid-march.

Configuration
REQ-032 With ALIEN_SPEEDUP_EN defined: period = STEP_FRAMES when live count > 25, STEP_FRAMES/2 when 11-25, STEP_FRAMES/4 when <= 10 (min 1); counter resets to 0 when the period changes.
REQ-033 Without ALIEN_SPEEDUP_EN: period is always STEP_FRAMES; the live-count logic is absent.

Structure
REQ-034 Package aliens_pkg SHALL hold grid dimensions, cell sizes, pitches, screen width 640, and the state enum; shared with the draw stage.
REQ-035 Sub-module alien_hit_index SHALL be combinational: position+bullet+grid -> hit valid and 6-bit index.

Verification
REQ-036 Reset, 30 FrameTicks -> AliensCol 40->50, Row 40, state MARCH_R.
REQ-037 Full grid, AliensCol=250, MARCH_R, step -> Row 40->50, Col 250, MARCH_L.
REQ-038 Bullet (Row 45, Col 85) at reset position -> bit 1 clears, BulletHit one cycle; repeat -> no pulse.
REQ-039 Bullet (Row 45, Col 75) (gap) -> grid unchanged, no BulletHit.
REQ-040 Clear all 50 bits -> AliensCleared=1; further FrameTicks leave Col/Row unchanged.
REQ-041 Drive AliensRow to 270 with full grid, step -> bottom 410 >= 400 -> AliensLanded=1, frozen; Reset -> initial values.
